// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
//   fwd_sel_t  : E-stage operand forward select (RD file, M, W or long-unit result)
//   PCSRC_SEQ  : Ei_prePCSrc encoding for sequential fetch (no redirect)
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RD = 2'b00,
        FWD_M  = 2'b01,
        FWD_W  = 2'b10,
        FWD_L  = 2'b11
    } fwd_sel_t;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Bundle of pipeline-stage signals exchanged between the controller/datapath and the
// hazard unit.
//   master : controller side, drives stage information, receives stall/flush/forward selects
//   slave  : hazard unit side
// Parameter REG_AW : register index width.
interface hazard_scoreboard_if #(
    parameter int unsigned REG_AW = 5
);
    // D stage
    logic [REG_AW-1:0] Di_rs1, Di_rs2, Di_rd;
    logic              Di_regWrite, Di_longOp, Di_jal, Di_mret;
    // E stage
    logic [REG_AW-1:0] Ei_rs1, Ei_rs2, Ei_rd;
    logic [1:0]        Ei_prePCSrc;
    logic              Ei_resultWSrc, Ei_longOp;
    // M / W stages
    logic [REG_AW-1:0] Mi_rd, Wi_rd;
    logic              Mi_regWrite, Wi_regWrite;
    // long-latency unit writeback
    logic              Li_done;
    logic [REG_AW-1:0] Li_rd;
    // hazard unit outputs
    logic [1:0]        Eo_forwardIn1Src, Eo_forwardIn2Src;
    logic              Fo_stall, Do_stall, Do_flush, Eo_flush;
    logic              Lo_issue, Lo_full;

    modport master (
        output Di_rs1, Di_rs2, Di_rd, Di_regWrite, Di_longOp, Di_jal, Di_mret,
        output Ei_rs1, Ei_rs2, Ei_rd, Ei_prePCSrc, Ei_resultWSrc, Ei_longOp,
        output Mi_rd, Wi_rd, Mi_regWrite, Wi_regWrite, Li_done, Li_rd,
        input  Eo_forwardIn1Src, Eo_forwardIn2Src, Fo_stall, Do_stall, Do_flush, Eo_flush,
        input  Lo_issue, Lo_full
    );

    modport slave (
        input  Di_rs1, Di_rs2, Di_rd, Di_regWrite, Di_longOp, Di_jal, Di_mret,
        input  Ei_rs1, Ei_rs2, Ei_rd, Ei_prePCSrc, Ei_resultWSrc, Ei_longOp,
        input  Mi_rd, Wi_rd, Mi_regWrite, Wi_regWrite, Li_done, Li_rd,
        output Eo_forwardIn1Src, Eo_forwardIn2Src, Fo_stall, Do_stall, Do_flush, Eo_flush,
        output Lo_issue, Lo_full
    );

endinterface

// File: rtl/hazard_fwd_sel.sv
// Forward-source priority for one E-stage source register. Purely combinational.
//   rs_i              : E-stage source register
//   m_rd_i, m_we_i    : M-stage destination / write enable
//   w_rd_i, w_we_i    : W-stage destination / write enable
//   l_done_i, l_rd_i  : long unit writeback this cycle / its destination
//   sel_o             : selected source (r0 always reads the register file)
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] m_rd_i,
    input  logic              m_we_i,
    input  logic [REG_AW-1:0] w_rd_i,
    input  logic              w_we_i,
    input  logic              l_done_i,
    input  logic [REG_AW-1:0] l_rd_i,
    output fwd_sel_t          sel_o
);

    // Youngest producer wins: M, then the long unit, then W.
    always_comb begin
        sel_o = FWD_RD;
        if (rs_i != '0) begin
            if (m_we_i && (m_rd_i == rs_i)) begin
                sel_o = FWD_M;
            end else if (l_done_i && (l_rd_i == rs_i)) begin
                sel_o = FWD_L;
            end else if (w_we_i && (w_rd_i == rs_i)) begin
                sel_o = FWD_W;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: E-stage forwarding, load-use stall, redirect flush and a register
// scoreboard for a multi-cycle long-latency unit with up to LONG_DEPTH ops in flight.
// Ports:
//   clk          : clock, all state on rising edge
//   reset_x      : asynchronous active-low reset, clears scoreboard and counters
//   bus          : hazard_scoreboard_if.slave, stage inputs and stall/flush/forward outputs
//   So_stallCnt  : saturating count of F-stall cycles (only with HAZARD_STALL_CNT_EN)
// Optional feature macro: HAZARD_STALL_CNT_EN enables the stall counter and its port.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned LONG_DEPTH = 2,
    parameter int unsigned CNT_W      = 32
) (
    input  logic              clk,
    input  logic              reset_x,
`ifdef HAZARD_STALL_CNT_EN
    output logic [CNT_W-1:0]  So_stallCnt,
`endif
    hazard_scoreboard_if.slave bus
);

    localparam int unsigned NREG   = 1 << REG_AW;
    localparam logic [2:0]  DEPTH3 = 3'(LONG_DEPTH);
    localparam logic [3:0]  DEPTH4 = 4'(LONG_DEPTH);

    if (CNT_W == 0 || LONG_DEPTH == 0 || LONG_DEPTH > 7) begin : g_param_check
        $error("hazard_scoreboard: CNT_W must be >0 and LONG_DEPTH in 1..7");
    end

    logic [NREG-1:0] busy_q, busy_d;
    logic [2:0]      outst_q, outst_d;

    // A register is pending if a long op owns it, unless that op writes back this cycle,
    // or if a long op targeting it issues this cycle.
    function automatic logic is_pend(
        input logic [REG_AW-1:0] r,
        input logic [NREG-1:0]   busy,
        input logic              issue,
        input logic [REG_AW-1:0] issue_rd,
        input logic              done,
        input logic [REG_AW-1:0] done_rd
    );
        return (r != '0) && ((busy[r] && !(done && (done_rd == r))) ||
                             (issue && (issue_rd == r)));
    endfunction

    // ---------------- forwarding ----------------
    fwd_sel_t fwd1, fwd2;

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd1 (
        .rs_i     (bus.Ei_rs1),
        .m_rd_i   (bus.Mi_rd),
        .m_we_i   (bus.Mi_regWrite),
        .w_rd_i   (bus.Wi_rd),
        .w_we_i   (bus.Wi_regWrite),
        .l_done_i (bus.Li_done),
        .l_rd_i   (bus.Li_rd),
        .sel_o    (fwd1)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd2 (
        .rs_i     (bus.Ei_rs2),
        .m_rd_i   (bus.Mi_rd),
        .m_we_i   (bus.Mi_regWrite),
        .w_rd_i   (bus.Wi_rd),
        .w_we_i   (bus.Wi_regWrite),
        .l_done_i (bus.Li_done),
        .l_rd_i   (bus.Li_rd),
        .sel_o    (fwd2)
    );

    assign bus.Eo_forwardIn1Src = fwd1;
    assign bus.Eo_forwardIn2Src = fwd2;

    // ---------------- stall / flush ----------------
    logic       issue, done_ok, redir;
    logic       lw_stall, sb_stall, struct_stall, stall;
    logic [3:0] long_cnt;

    assign issue = bus.Ei_longOp;
    // Spurious completions never decrement. r0 ops are never marked busy, so their
    // completion only needs an outstanding op to retire.
    assign done_ok = bus.Li_done && (outst_q != '0) &&
                     (busy_q[bus.Li_rd] || (bus.Li_rd == '0));

    assign redir    = bus.Ei_prePCSrc != PCSRC_SEQ;
    assign lw_stall = bus.Ei_resultWSrc && (bus.Ei_rd != '0) &&
                      ((bus.Di_rs1 == bus.Ei_rd) || (bus.Di_rs2 == bus.Ei_rd));

    assign long_cnt     = {1'b0, outst_q} + {3'b000, issue};
    assign struct_stall = bus.Di_longOp && (long_cnt >= DEPTH4);

    assign sb_stall =
        is_pend(bus.Di_rs1, busy_q, issue, bus.Ei_rd, bus.Li_done, bus.Li_rd) ||
        is_pend(bus.Di_rs2, busy_q, issue, bus.Ei_rd, bus.Li_done, bus.Li_rd) ||
        (bus.Di_regWrite &&
         is_pend(bus.Di_rd, busy_q, issue, bus.Ei_rd, bus.Li_done, bus.Li_rd)) ||
        struct_stall;

    assign stall        = lw_stall || sb_stall;
    assign bus.Fo_stall = stall && !redir;
    assign bus.Do_stall = stall && !redir;
    assign bus.Do_flush = redir || bus.Di_jal || bus.Di_mret;
    assign bus.Eo_flush = redir || stall;
    assign bus.Lo_issue = issue;
    assign bus.Lo_full  = outst_q == DEPTH3;

    // ---------------- scoreboard ----------------
    always_comb begin
        busy_d  = busy_q;
        outst_d = outst_q;
        case ({issue, done_ok})
            2'b10:   outst_d = outst_q + 3'd1;
            2'b01:   outst_d = outst_q - 3'd1;
            default: outst_d = outst_q;
        endcase
        if (bus.Li_done) begin
            busy_d[bus.Li_rd] = 1'b0;
        end
        // Set after clear so an issue to the completing rd keeps it busy.
        if (issue && (bus.Ei_rd != '0)) begin
            busy_d[bus.Ei_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            busy_q  <= '0;
            outst_q <= '0;
        end else begin
            busy_q  <= busy_d;
            outst_q <= outst_d;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            stall_cnt_q <= '0;
        end else if (bus.Fo_stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign So_stallCnt = stall_cnt_q;
`endif

    // ---------------- protocol checks ----------------
    a_done_valid : assert property (@(posedge clk) disable iff (!reset_x)
        bus.Li_done |-> done_ok);

    // A completion in the same cycle frees the slot the new issue takes.
    a_issue_room : assert property (@(posedge clk) disable iff (!reset_x)
        issue |-> ((outst_q != DEPTH3) || done_ok));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard (REG_AW=5, LONG_DEPTH=2).
module tb_hazard_scoreboard;

    localparam int unsigned REG_AW = 5;

    // Packed output view: {fwd1, fwd2, Fo_stall, Do_stall, Do_flush, Eo_flush, Lo_issue, Lo_full}
    localparam int F1M = 'h100;
    localparam int F1W = 'h200;
    localparam int F1L = 'h300;
    localparam int F2M = 'h040;
    localparam int F2W = 'h080;
    localparam int ST  = 'h030;
    localparam int DF  = 'h008;
    localparam int EF  = 'h004;
    localparam int IS  = 'h002;
    localparam int FU  = 'h001;

    logic clk = 1'b0;
    logic reset_x;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_AW(REG_AW)) bus ();

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    hazard_scoreboard #(
        .REG_AW     (REG_AW),
        .LONG_DEPTH (2),
        .CNT_W      (32)
    ) dut (
        .clk         (clk),
        .reset_x     (reset_x),
`ifdef HAZARD_STALL_CNT_EN
        .So_stallCnt (stall_cnt),
`endif
        .bus         (bus)
    );

    typedef struct {
        string name;
        logic [9:0] v;
    } exp_t;

    typedef struct {
        string name;
        int d_rs1, d_rs2, d_jal, d_mret;
        int e_rs1, e_rs2, e_rd, e_load, e_pcsrc;
        int m_rd, m_we, w_rd, w_we;
        int exp;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [9:0] outs();
        return {bus.Eo_forwardIn1Src, bus.Eo_forwardIn2Src, bus.Fo_stall, bus.Do_stall,
                bus.Do_flush, bus.Eo_flush, bus.Lo_issue, bus.Lo_full};
    endfunction

    task automatic check_front();
        exp_t       e;
        logic [9:0] a;
        e = exp_q.pop_front();
        a = outs();
        n_cmp++;
        if (a !== e.v) begin
            n_bad++;
            $display("FAIL %s: got %b required %b", e.name, a, e.v);
        end
    endtask

    // Push the expected result for the stimulus just driven, let it settle, then compare.
    task automatic expect_outs(input string name, input int v);
        exp_t e;
        e.name = name;
        e.v    = 10'(v);
        exp_q.push_back(e);
        #1;
        check_front();
    endtask

    task automatic idle();
        bus.Di_rs1 = '0; bus.Di_rs2 = '0; bus.Di_rd = '0;
        bus.Di_regWrite = 1'b0; bus.Di_longOp = 1'b0; bus.Di_jal = 1'b0; bus.Di_mret = 1'b0;
        bus.Ei_rs1 = '0; bus.Ei_rs2 = '0; bus.Ei_rd = '0; bus.Ei_prePCSrc = 2'b00;
        bus.Ei_resultWSrc = 1'b0; bus.Ei_longOp = 1'b0;
        bus.Mi_rd = '0; bus.Wi_rd = '0; bus.Mi_regWrite = 1'b0; bus.Wi_regWrite = 1'b0;
        bus.Li_done = 1'b0; bus.Li_rd = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got still running required finished");
        $fatal(1);
    end

    initial begin
        //          name            drs1 drs2 jal mret ers1 ers2 erd ld pcs mrd mwe wrd wwe exp
        vecs.push_back('{"idle",          0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0});
        vecs.push_back('{"fwd_m_over_w",  0, 0, 0, 0,  5, 0, 0, 0, 0,  5, 1, 5, 1, F1M});
        vecs.push_back('{"fwd_w",         0, 0, 0, 0,  5, 0, 0, 0, 0,  5, 0, 5, 1, F1W});
        vecs.push_back('{"fwd_r0",        0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 1, 0});
        vecs.push_back('{"fwd_both_m",    0, 0, 0, 0,  6, 6, 0, 0, 0,  6, 1, 0, 0, F1M | F2M});
        vecs.push_back('{"fwd_rs2_w",     0, 0, 0, 0,  0, 8, 0, 0, 0,  9, 1, 8, 1, F2W});
        vecs.push_back('{"load_use_rs2",  0, 7, 0, 0,  0, 0, 7, 1, 0,  0, 0, 0, 0, ST | EF});
        vecs.push_back('{"load_use_rs1",  7, 3, 0, 0,  0, 0, 7, 1, 0,  0, 0, 0, 0, ST | EF});
        vecs.push_back('{"load_redir",    0, 7, 0, 0,  0, 0, 7, 1, 1,  0, 0, 0, 0, DF | EF});
        vecs.push_back('{"load_rd0",      0, 0, 0, 0,  0, 0, 0, 1, 0,  0, 0, 0, 0, 0});
        vecs.push_back('{"load_nomatch",  8, 3, 0, 0,  0, 0, 7, 1, 0,  0, 0, 0, 0, 0});
        vecs.push_back('{"jal",           0, 0, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, DF});
        vecs.push_back('{"mret",          0, 0, 0, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, DF});
        vecs.push_back('{"redir_10",      0, 0, 0, 0,  0, 0, 0, 0, 2,  0, 0, 0, 0, DF | EF});

        reset_x = 1'b0;
        idle();
        #12;
        expect_outs("reset_state", 0);
        @(negedge clk);
        reset_x = 1'b1;
        tick();

        foreach (vecs[i]) begin
            idle();
            bus.Di_rs1        = 5'(vecs[i].d_rs1);
            bus.Di_rs2        = 5'(vecs[i].d_rs2);
            bus.Di_jal        = 1'(vecs[i].d_jal);
            bus.Di_mret       = 1'(vecs[i].d_mret);
            bus.Ei_rs1        = 5'(vecs[i].e_rs1);
            bus.Ei_rs2        = 5'(vecs[i].e_rs2);
            bus.Ei_rd         = 5'(vecs[i].e_rd);
            bus.Ei_resultWSrc = 1'(vecs[i].e_load);
            bus.Ei_prePCSrc   = 2'(vecs[i].e_pcsrc);
            bus.Mi_rd         = 5'(vecs[i].m_rd);
            bus.Mi_regWrite   = 1'(vecs[i].m_we);
            bus.Wi_rd         = 5'(vecs[i].w_rd);
            bus.Wi_regWrite   = 1'(vecs[i].w_we);
            expect_outs(vecs[i].name, vecs[i].exp);
            tick();
        end

        // Long op to x9, dependent D instruction waits for writeback.
        idle(); bus.Ei_longOp = 1'b1; bus.Ei_rd = 5'd9; bus.Di_rs1 = 5'd9;
        expect_outs("long_issue_raw", IS | ST | EF);
        tick();
        idle(); bus.Di_rs1 = 5'd9;
        expect_outs("long_busy_raw", ST | EF);
        tick();
        idle(); bus.Di_rs1 = 5'd9; bus.Ei_rs1 = 5'd9; bus.Li_done = 1'b1; bus.Li_rd = 5'd9;
        expect_outs("long_done_fwd", F1L);
        tick();
        idle(); bus.Di_rs1 = 5'd9;
        expect_outs("long_cleared", 0);
        tick();

        // Fill to LONG_DEPTH, structural stall, done+issue in the same cycle.
        idle(); bus.Ei_longOp = 1'b1; bus.Ei_rd = 5'd3;
        expect_outs("fill_issue3", IS);
        tick();
        idle(); bus.Ei_longOp = 1'b1; bus.Ei_rd = 5'd4;
        bus.Di_longOp = 1'b1; bus.Di_regWrite = 1'b1; bus.Di_rd = 5'd10;
        expect_outs("fill_issue4_struct", IS | ST | EF);
        tick();
        idle(); bus.Di_longOp = 1'b1; bus.Di_regWrite = 1'b1; bus.Di_rd = 5'd10;
        expect_outs("full_struct_stall", ST | EF | FU);
        tick();
        idle(); bus.Li_done = 1'b1; bus.Li_rd = 5'd3; bus.Ei_longOp = 1'b1; bus.Ei_rd = 5'd6;
        bus.Di_rs1 = 5'd3;
        expect_outs("done_issue_same", IS | FU);
        tick();
        idle(); bus.Di_rs1 = 5'd6;
        expect_outs("still_full_raw6", ST | EF | FU);
        tick();
        idle(); bus.Li_done = 1'b1; bus.Li_rd = 5'd4;
        expect_outs("drain4", FU);
        tick();
        idle(); bus.Li_done = 1'b1; bus.Li_rd = 5'd6;
        expect_outs("drain6", 0);
        tick();
        idle(); bus.Di_rs2 = 5'd6;
        expect_outs("drained_no_stall", 0);
        tick();

        // r0 long op, WAW on x12, then asynchronous reset mid-flight.
        idle(); bus.Ei_longOp = 1'b1; bus.Ei_rd = 5'd0; bus.Di_regWrite = 1'b1; bus.Di_rd = 5'd0;
        expect_outs("issue_r0", IS);
        tick();
        idle(); bus.Ei_longOp = 1'b1; bus.Ei_rd = 5'd12;
        expect_outs("issue_r12", IS);
        tick();
        idle(); bus.Di_regWrite = 1'b1; bus.Di_rd = 5'd12;
        expect_outs("waw_r12", ST | EF | FU);
        tick();
        idle(); bus.Di_regWrite = 1'b1; bus.Di_rd = 5'd0;
        expect_outs("x0_no_waw", FU);
        @(negedge clk);
        bus.Di_rd = 5'd12;
        reset_x = 1'b0;
        expect_outs("reset_midflight", 0);
        @(negedge clk);
        reset_x = 1'b1;
        idle();
        tick();
        idle(); bus.Di_rs1 = 5'd12;
        expect_outs("post_reset_clear", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
